// File: rtl/hdmi_tx_pkg.sv
// Shared types and default 720p60 timing for the HDMI transmit path.
package hdmi_tx_pkg;

  // Lock state of the stream-to-raster aligner.
  typedef enum logic [0:0] {
    WAIT_SOF,
    LOCKED
  } framer_state_t;

  // One pixel as carried to the three TMDS lanes {2,1,0} = {R,G,B}.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // CEA-861 1280x720p60 raster.
  localparam int unsigned H_ACTIVE_720P = 1280;
  localparam int unsigned H_FP_720P     = 110;
  localparam int unsigned H_SYNC_720P   = 40;
  localparam int unsigned H_BP_720P     = 220;
  localparam int unsigned V_ACTIVE_720P = 720;
  localparam int unsigned V_FP_720P     = 5;
  localparam int unsigned V_SYNC_720P   = 5;
  localparam int unsigned V_BP_720P     = 20;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Free-running raster counters with active-region and sync decode.
// Decodes are combinational from the counters; the caller registers them.
module video_timing_gen
  import hdmi_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_720P,
  parameter int unsigned H_FP     = H_FP_720P,
  parameter int unsigned H_SYNC   = H_SYNC_720P,
  parameter int unsigned H_BP     = H_BP_720P,
  parameter int unsigned V_ACTIVE = V_ACTIVE_720P,
  parameter int unsigned V_FP     = V_FP_720P,
  parameter int unsigned V_SYNC   = V_SYNC_720P,
  parameter int unsigned V_BP     = V_BP_720P,
  parameter int unsigned HCW      = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int unsigned VCW      = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  output logic [HCW-1:0] h_cnt_o,
  output logic [VCW-1:0] v_cnt_o,
  output logic           active_o,
  output logic           hsync_act_o,
  output logic           vsync_act_o
);

  localparam int unsigned HTot     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HsStart  = H_ACTIVE + H_FP;
  localparam int unsigned HsEnd    = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VsStart  = V_ACTIVE + V_FP;
  localparam int unsigned VsEnd    = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [HCW-1:0] HLast = HCW'(HTot - 1);
  localparam logic [VCW-1:0] VLast = VCW'(VTot - 1);

  logic [HCW-1:0] h_cnt_d, h_cnt_q;
  logic [VCW-1:0] v_cnt_d, v_cnt_q;

  // Compare in 32 bits so end-of-range constants equal to the total still fit.
  logic [31:0] h_pos, v_pos;
  assign h_pos = 32'(h_cnt_q);
  assign v_pos = 32'(v_cnt_q);

  // Next raster position: h wraps every line, v wraps every frame.
  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HLast) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
    end
  end

  // Raster position state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Region decode for the current position; sync levels are active-high here.
  always_comb begin
    active_o    = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
    hsync_act_o = (h_pos >= HsStart) && (h_pos < HsEnd);
    vsync_act_o = (v_pos >= VsStart) && (v_pos < VsEnd);
  end

  assign h_cnt_o = h_cnt_q;
  assign v_cnt_o = v_cnt_q;

endmodule

// File: rtl/hdmi_video_framer.sv
// Aligns an upstream RGB beat stream (sof/eol framed) onto a free-running
// raster and presents registered pixel, DE and sync to the TMDS lanes.
// Lane 0 control bits carry {vsync, hsync}; lanes 1/2 control are tied low
// outside this block.
module hdmi_video_framer
  import hdmi_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_720P,
  parameter int unsigned H_FP       = H_FP_720P,
  parameter int unsigned H_SYNC     = H_SYNC_720P,
  parameter int unsigned H_BP       = H_BP_720P,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_720P,
  parameter int unsigned V_FP       = V_FP_720P,
  parameter int unsigned V_SYNC     = V_SYNC_720P,
  parameter int unsigned V_BP       = V_BP_720P,
  parameter logic        H_POL      = 1'b1,
  parameter logic        V_POL      = 1'b1,
  parameter logic [23:0] FILL_COLOR = 24'h000000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [23:0] vid_data_i,
  input  logic        vid_valid_i,
  input  logic        vid_sof_i,
  input  logic        vid_eol_i,
  output logic        vid_ready_o,
  output logic [23:0] px_data_o,
  output logic        px_data_val_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        sync_err_o
);

  localparam int unsigned HCW = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int unsigned VCW = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP);

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic           active;
  logic           hsync_act;
  logic           vsync_act;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HCW      (HCW),
    .VCW      (VCW)
  ) u_timing (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .h_cnt_o     (h_cnt),
    .v_cnt_o     (v_cnt),
    .active_o    (active),
    .hsync_act_o (hsync_act),
    .vsync_act_o (vsync_act)
  );

  logic origin;
  logic line_end;
  assign origin   = (h_cnt == '0) && (v_cnt == '0);
  assign line_end = (32'(h_cnt) == H_ACTIVE - 1);

  rgb_t fill_rgb;
  rgb_t beat_rgb;
  assign fill_rgb = rgb_t'(FILL_COLOR);
  assign beat_rgb = rgb_t'(vid_data_i);

  framer_state_t state_d, state_q;
  rgb_t          px_d, px_q;
  logic          de_d, de_q;
  logic          hs_d, hs_q;
  logic          vs_d, vs_q;
  logic          err_d, err_q;
  logic          slot_owned;

  // Ready depends only on state, position and sof, never on valid. While
  // hunting, a sof beat is parked until the frame origin; once locked, a
  // sof away from the origin is refused so it can open the next frame.
  always_comb begin
    if (!rst_n_i) begin
      vid_ready_o = 1'b0;
    end else if (state_q == WAIT_SOF) begin
      vid_ready_o = !vid_sof_i || origin;
    end else begin
      vid_ready_o = active && (origin || !vid_sof_i);
    end
  end

  // Per-slot decision: which pixel to show, whether the stream broke lock.
  always_comb begin
    state_d = state_q;
    px_d    = '0;
    de_d    = active;
    hs_d    = hsync_act ? H_POL : ~H_POL;
    vs_d    = vsync_act ? V_POL : ~V_POL;
    err_d   = 1'b0;

    // A sof beat landing on the origin while hunting is the locking beat
    // and goes through the same checks as any locked slot.
    slot_owned = (state_q == LOCKED) || (origin && vid_valid_i && vid_sof_i);

    if (active) begin
      px_d = fill_rgb;
      if (slot_owned) begin
        if (!vid_valid_i) begin
          err_d = 1'b1;
        end else if (vid_sof_i && !origin) begin
          err_d = 1'b1;
        end else if (!vid_sof_i && origin) begin
          err_d = 1'b1;
        end else if (vid_eol_i != line_end) begin
          err_d = 1'b1;
        end else begin
          px_d = beat_rgb;
        end
        state_d = err_d ? WAIT_SOF : LOCKED;
      end
    end
  end

  // Lock state and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= WAIT_SOF;
      px_q    <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~H_POL;
      vs_q    <= ~V_POL;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      err_q   <= err_d;
    end
  end

  assign px_data_o     = px_q;
  assign px_data_val_o = de_q;
  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;
  assign sync_err_o    = err_q;

endmodule
